// File: rtl/apb2axi_reg_gw_v2.sv
// ---------------------------------------------------------------------------
// apb2axi_reg_gw_v2
//
// APB3 register gateway for the APB->AXI bridge. Software stages an AXI
// command in ADDR_LO/ADDR_HI/CMD and writes COMMIT. The gateway then holds
// the command on a valid/ready handshake to the directory. Completions are
// consumed by reading STATUS. For a read completion with beats, the gateway
// asks the RDF to stream that tag. Each beat is returned through RD_DATA,
// with APB wait states until the beat arrives. A wait that runs too long
// ends the access with an error.
//
// Optional feature (define APB2AXI_REG_IRQ_EN):
//   IRQ_CTRL at 0x1C, bit 0 = enable (RW), bit 1 = pending (W1C).
//   Pending is set when sts_valid rises, and irq = enable & pending.
//   Without the macro, irq is tied to 0 and 0x1C is unmapped.
//
// Ports
//   pclk, presetn            clock, async active-low reset
//   psel/penable/pwrite      APB control
//   paddr, pwdata            APB address / write data (paddr[4:2] decoded)
//   pready/pslverr/prdata    APB completion, error, read data (combinational)
//   cmd_valid/cmd_ready      command handshake to the directory
//   cmd_addr/len/size/is_wr  snapshot of the committed command
//   sts_*                    head of the completion status queue
//   sts_pop_valid/_tag       1-cycle consume acknowledge
//   rdf_req/rdf_req_tag      1-cycle request to start a beat stream
//   rdf_valid/ready/data/last  beat handshake from the read data FIFO
//   irq                      completion interrupt
// ---------------------------------------------------------------------------
module apb2axi_reg_gw_v2 #(
  parameter int AXI_ADDR_W = 64,
  parameter int APB_ADDR_W = 16,
  parameter int APB_DATA_W = 32,
  parameter int TAG_W      = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [AXI_ADDR_W-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic [2:0]            cmd_size,
  output logic                  cmd_is_write,
  input  logic                  sts_valid,
  input  logic                  sts_error,
  input  logic [1:0]            sts_resp,
  input  logic                  sts_is_write,
  input  logic [TAG_W-1:0]      sts_tag,
  input  logic [7:0]            sts_num_beats,
  output logic                  sts_pop_valid,
  output logic [TAG_W-1:0]      sts_pop_tag,
  output logic                  rdf_req,
  output logic [TAG_W-1:0]      rdf_req_tag,
  input  logic                  rdf_valid,
  output logic                  rdf_ready,
  input  logic [31:0]           rdf_data,
  input  logic                  rdf_last,
  output logic                  irq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  localparam logic [2:0] SEL_ADDR_LO  = 3'd0;
  localparam logic [2:0] SEL_ADDR_HI  = 3'd1;
  localparam logic [2:0] SEL_CMD      = 3'd2;
  localparam logic [2:0] SEL_COMMIT   = 3'd3;
  localparam logic [2:0] SEL_STATUS   = 3'd4;
  localparam logic [2:0] SEL_RD_DATA  = 3'd5;
  localparam logic [2:0] SEL_INFO     = 3'd6;
`ifdef APB2AXI_REG_IRQ_EN
  localparam logic [2:0] SEL_IRQ_CTRL = 3'd7;
`endif

  localparam logic [15:0] TMO_LIMIT = 16'(RD_TIMEOUT);

  state_t state_q, state_d;

  logic [APB_DATA_W-1:0] addr_lo_q, addr_hi_q, cmd_q;
  logic [31:0]           snap_lo_q, snap_hi_q;
  logic [7:0]            snap_len_q;
  logic [2:0]            snap_size_q;
  logic                  snap_is_write_q;
  logic [63:0]           snap_addr_full;
  logic [TAG_W-1:0]      armed_tag_q;
  logic [15:0]           wait_cnt_q;
  logic [7:0]            tmo_cnt_q, drop_cnt_q;

  logic [2:0]            reg_sel;
  logic                  apb_acc, reg_wr, apb_rd, commit_wr;
  logic                  status_rd, rd_data_acc;
  logic                  pop_fire, rd_timeout, rd_wait;
  logic [31:0]           status_word, info_word;
  logic                  unused_paddr_bits;

  assign reg_sel     = paddr[4:2];
  assign apb_acc     = psel & penable;
  assign reg_wr      = apb_acc & pwrite;
  assign apb_rd      = apb_acc & ~pwrite;
  assign commit_wr   = reg_wr & (reg_sel == SEL_COMMIT);
  assign status_rd   = apb_rd & (reg_sel == SEL_STATUS);
  assign rd_data_acc = apb_rd & (reg_sel == SEL_RD_DATA);
  assign rd_wait     = rdf_ready & ~rdf_valid;

  assign unused_paddr_bits = ^{paddr[APB_ADDR_W-1:5], paddr[1:0]};

  // The command outputs come from the snapshot taken at COMMIT. Software can
  // therefore prepare the next command while this one waits for cmd_ready.
  assign snap_addr_full = {snap_hi_q, snap_lo_q};
  assign cmd_addr       = snap_addr_full[AXI_ADDR_W-1:0];
  assign cmd_len        = snap_len_q;
  assign cmd_size       = snap_size_q;
  assign cmd_is_write   = snap_is_write_q;
  assign rdf_req_tag    = armed_tag_q;

  // Read-only views of the completion head and of gateway health.
  always_comb begin
    status_word                = '0;
    status_word[31]            = sts_valid;
    status_word[30]            = sts_error;
    status_word[29:28]         = sts_resp;
    status_word[27]            = sts_is_write;
    status_word[26]            = (state_q != S_IDLE);
    status_word[23:16]         = sts_num_beats;
    status_word[TAG_W-1:0]     = sts_tag;

    info_word                  = '0;
    info_word[0]               = cmd_valid;
    info_word[2:1]             = state_q;
    info_word[15:8]            = tmo_cnt_q;
    info_word[23:16]           = drop_cnt_q;
  end

  // Stream FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stream FSM next state and strobes. A completion is popped only in IDLE,
  // so a STATUS read during a stream returns data but has no side effects.
  // Once the wait counter reaches the limit, ready is withheld for that
  // cycle, so a late beat is never consumed by an access that has already
  // timed out.
  always_comb begin
    state_d    = state_q;
    pop_fire   = 1'b0;
    rdf_req    = 1'b0;
    rdf_ready  = 1'b0;
    rd_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (status_rd && sts_valid) begin
          pop_fire = 1'b1;
          if (!sts_is_write && (sts_num_beats != 8'd0)) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        rdf_req = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_data_acc) begin
          if (wait_cnt_q == TMO_LIMIT) begin
            rd_timeout = 1'b1;
          end else begin
            rdf_ready = 1'b1;
            if (rdf_valid && rdf_last) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef APB2AXI_REG_IRQ_EN
  logic irq_en_q, irq_pend_q, sts_valid_q;
  logic irq_en_d, irq_pend_d, irq_wr;

  assign irq_wr = reg_wr & (reg_sel == SEL_IRQ_CTRL);

  // The set from a rising sts_valid is applied after the W1C. If both happen
  // in the same cycle, pending stays set and the new completion is not lost.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (irq_wr) begin
      irq_en_d = pwdata[0];
      if (pwdata[1]) begin
        irq_pend_d = 1'b0;
      end
    end
    if (sts_valid && !sts_valid_q) begin
      irq_pend_d = 1'b1;
    end
  end

  // Interrupt registers. irq is registered from the next-state values, so it
  // follows pending without an extra cycle of lag.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      sts_valid_q <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      irq_pend_q  <= irq_pend_d;
      sts_valid_q <= sts_valid;
      irq         <= irq_en_d & irq_pend_d;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // APB response decode. Every access completes without wait states, except
  // an RD_DATA read during a stream, which waits for a beat or for the
  // timeout. On an error, prdata is left at zero.
  always_comb begin
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = '0;
    if (apb_acc) begin
      case (reg_sel)
        SEL_ADDR_LO: if (!pwrite) prdata = addr_lo_q;
        SEL_ADDR_HI: if (!pwrite) prdata = addr_hi_q;
        SEL_CMD:     if (!pwrite) prdata = cmd_q;
        SEL_COMMIT:  if (!pwrite || cmd_valid) pslverr = 1'b1;
        SEL_STATUS: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = status_word;
        end
        SEL_RD_DATA: begin
          if (pwrite || (state_q != S_STREAM) || rd_timeout) begin
            pslverr = 1'b1;
          end else begin
            pready = rdf_valid;
            if (rdf_valid) prdata = rdf_data;
          end
        end
        SEL_INFO: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = info_word;
        end
`ifdef APB2AXI_REG_IRQ_EN
        SEL_IRQ_CTRL: if (!pwrite) prdata = {30'd0, irq_pend_q, irq_en_q};
`endif
        default: pslverr = 1'b1;
      endcase
    end
  end

  // Staging registers and the command handshake. A COMMIT while a command is
  // still pending is rejected and counted. The pending command is not
  // touched.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_lo_q       <= '0;
      addr_hi_q       <= '0;
      cmd_q           <= '0;
      snap_lo_q       <= '0;
      snap_hi_q       <= '0;
      snap_len_q      <= '0;
      snap_size_q     <= '0;
      snap_is_write_q <= 1'b0;
      cmd_valid       <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      if (reg_wr) begin
        case (reg_sel)
          SEL_ADDR_LO: addr_lo_q <= pwdata;
          SEL_ADDR_HI: addr_hi_q <= pwdata;
          SEL_CMD:     cmd_q     <= pwdata;
          default: ;
        endcase
      end
      if (commit_wr && !cmd_valid) begin
        snap_lo_q       <= addr_lo_q;
        snap_hi_q       <= addr_hi_q;
        snap_len_q      <= cmd_q[7:0];
        snap_size_q     <= cmd_q[10:8];
        snap_is_write_q <= cmd_q[31];
        cmd_valid       <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (commit_wr && cmd_valid && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Pop acknowledge and armed tag. The pop is a single-cycle pulse taken
  // from the FSM strobe. The armed tag holds the stream identity for the
  // request that follows.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sts_pop_valid <= 1'b0;
      sts_pop_tag   <= '0;
      armed_tag_q   <= '0;
    end else begin
      sts_pop_valid <= pop_fire;
      if (pop_fire) begin
        sts_pop_tag <= sts_tag;
        armed_tag_q <= sts_tag;
      end
    end
  end

  // Wait-state counter for RD_DATA and the saturating timeout tally. The
  // counter restarts at every completed access, so each access gets the
  // full budget.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (apb_acc && pready) begin
        wait_cnt_q <= '0;
      end else if (rd_wait) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (rd_timeout && (tmo_cnt_q != 8'hFF)) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_reg_gw_v2.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_reg_gw_v2
//
// Self-checking bench for apb2axi_reg_gw_v2 with default parameters.
// Plain register accesses come from a vector table. The command handshake,
// the completion/stream flow, the timeout and reset are hand-written
// sequences. Expected pop tags and beat data are queued when the stimulus
// is set up, and are compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_apb2axi_reg_gw_v2;

  logic        pclk, presetn;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        cmd_valid, cmd_ready, cmd_is_write;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        sts_valid, sts_error, sts_is_write;
  logic [1:0]  sts_resp;
  logic [3:0]  sts_tag, sts_pop_tag, rdf_req_tag;
  logic [7:0]  sts_num_beats;
  logic        sts_pop_valid, rdf_req, rdf_valid, rdf_ready, rdf_last, irq;
  logic [31:0] rdf_data;

  apb2axi_reg_gw_v2 dut (
    .pclk(pclk), .presetn(presetn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_is_write(cmd_is_write),
    .sts_valid(sts_valid), .sts_error(sts_error), .sts_resp(sts_resp),
    .sts_is_write(sts_is_write), .sts_tag(sts_tag), .sts_num_beats(sts_num_beats),
    .sts_pop_valid(sts_pop_valid), .sts_pop_tag(sts_pop_tag),
    .rdf_req(rdf_req), .rdf_req_tag(rdf_req_tag),
    .rdf_valid(rdf_valid), .rdf_ready(rdf_ready),
    .rdf_data(rdf_data), .rdf_last(rdf_last),
    .irq(irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int passCount = 0;
  int checkCount = 0;

  // Beat source contents, written by the main sequence only.
  logic [31:0] beatMem[16];
  int          beatDelay[16];
  logic        beatLast[16];
  int          beatCount = 0;

  // Pulse observations, written by the monitor only.
  int         popCount = 0, reqCount = 0;
  logic [3:0] lastPopTag = '0, lastReqTag = '0;

  // Scoreboard queues.
  logic [3:0]  expPopQ[$];
  logic [31:0] expBeatQ[$];
  int          expWaitQ[$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // One APB transfer. It returns the response sampled in the completing cycle
  // and the number of wait states seen. The wait is bounded.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int waits);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    waits = 0;
    while (!pready && waits < 1000) begin
      @(posedge pclk); #2;
      waits++;
    end
    if (!pready) checkOutput("apb_wait_bound", {63'd0, pready}, 64'd1);
    rdata = prdata;
    err   = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Pulse monitor.
  initial begin
    forever begin
      @(negedge pclk);
      if (sts_pop_valid) begin popCount++; lastPopTag = sts_pop_tag; end
      if (rdf_req)       begin reqCount++; lastReqTag = rdf_req_tag; end
    end
  end

  // Beat source model. A beat's delay counts the cycles in which ready is
  // high but the beat is withheld, so delay N gives N APB wait states.
  initial begin
    int  beatIdx, delayLeft;
    bit  loaded, xfer, rdy;
    beatIdx = 0; delayLeft = 0; loaded = 0;
    rdf_valid = 1'b0; rdf_data = '0; rdf_last = 1'b0;
    forever begin
      @(negedge pclk);
      xfer = rdf_valid && rdf_ready;
      rdy  = rdf_ready;
      @(posedge pclk); #1;
      if (xfer) begin
        beatIdx++;
        loaded = 0;
      end else if (loaded && !rdf_valid && rdy && delayLeft > 0) begin
        delayLeft--;
      end
      if (!loaded && beatIdx < beatCount) begin
        delayLeft = beatDelay[beatIdx];
        loaded = 1;
      end
      if (loaded && delayLeft == 0) begin
        rdf_valid = 1'b1; rdf_data = beatMem[beatIdx]; rdf_last = beatLast[beatIdx];
      end else begin
        rdf_valid = 1'b0; rdf_last = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w, popBase, reqBase;

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cmd_ready = 1'b0;
    sts_valid = 1'b0; sts_error = 1'b0; sts_resp = '0; sts_is_write = 1'b0;
    sts_tag = '0; sts_num_beats = '0;

    vecs[0]  = '{1'b1, 16'h0000, 32'h0000_1000, 32'h0, 1'b0, "wr_addr_lo"};
    vecs[1]  = '{1'b1, 16'h0004, 32'h0000_0002, 32'h0, 1'b0, "wr_addr_hi"};
    vecs[2]  = '{1'b1, 16'h0008, 32'h0000_0203, 32'h0, 1'b0, "wr_cmd"};
    vecs[3]  = '{1'b0, 16'h0000, 32'h0, 32'h0000_1000, 1'b0, "rd_addr_lo"};
    vecs[4]  = '{1'b0, 16'h0004, 32'h0, 32'h0000_0002, 1'b0, "rd_addr_hi"};
    vecs[5]  = '{1'b0, 16'h0008, 32'h0, 32'h0000_0203, 1'b0, "rd_cmd"};
    vecs[6]  = '{1'b0, 16'h0100, 32'h0, 32'h0000_1000, 1'b0, "rd_alias_addr_lo"};
    vecs[7]  = '{1'b0, 16'h000C, 32'h0, 32'h0, 1'b1, "rd_commit_wo"};
    vecs[8]  = '{1'b1, 16'h0010, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_status_ro"};
    vecs[9]  = '{1'b1, 16'h0014, 32'h1234_5678, 32'h0, 1'b1, "wr_rd_data_ro"};
    vecs[10] = '{1'b1, 16'h0018, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_info_ro"};
    vecs[11] = '{1'b0, 16'h0014, 32'h0, 32'h0, 1'b1, "rd_data_idle"};
    vecs[12] = '{1'b0, 16'h0018, 32'h0, 32'h0, 1'b0, "rd_info_reset"};
    vecs[13] = '{1'b0, 16'h0010, 32'h0, 32'h0, 1'b0, "rd_status_empty"};
`ifdef APB2AXI_REG_IRQ_EN
    vecs[14] = '{1'b0, 16'h001C, 32'h0, 32'h0, 1'b0, "rd_irq_ctrl"};
`else
    vecs[14] = '{1'b0, 16'h001C, 32'h0, 32'h0, 1'b1, "rd_irq_unmapped"};
`endif

    tick(3);
    presetn = 1'b1;
    tick(1);

    $display("[TB] reset values");
    checkOutput("rst_pready", {63'd0, pready}, 64'd1);
    checkOutput("rst_pslverr", {63'd0, pslverr}, 64'd0);
    checkOutput("rst_prdata", {32'd0, prdata}, 64'd0);
    checkOutput("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    checkOutput("rst_pop", {63'd0, sts_pop_valid}, 64'd0);
    checkOutput("rst_rdf_req", {63'd0, rdf_req}, 64'd0);
    checkOutput("rst_rdf_ready", {63'd0, rdf_ready}, 64'd0);
    checkOutput("rst_irq", {63'd0, irq}, 64'd0);

    $display("[TB] register vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w);
      checkOutput({vecs[i].name, "_err"}, {63'd0, er}, {63'd0, vecs[i].expErr});
      if (!vecs[i].wr) checkOutput({vecs[i].name, "_data"}, {32'd0, rd}, {32'd0, vecs[i].expData});
    end
    tick(2);
    checkOutput("no_pop_when_empty", popCount, 0);

    $display("[TB] command commit and handshake");
    applyStimulus(1'b1, 16'h000C, 32'h0, rd, er, w);
    checkOutput("commit_err", {63'd0, er}, 64'd0);
    checkOutput("commit_valid", {63'd0, cmd_valid}, 64'd1);
    tick(5);
    checkOutput("commit_held", {63'd0, cmd_valid}, 64'd1);
    checkOutput("cmd_addr", cmd_addr, 64'h2_0000_1000);
    checkOutput("cmd_len", {56'd0, cmd_len}, 64'd3);
    checkOutput("cmd_size", {61'd0, cmd_size}, 64'd2);
    checkOutput("cmd_is_write", {63'd0, cmd_is_write}, 64'd0);
    applyStimulus(1'b1, 16'h0000, 32'hAAAA_0000, rd, er, w);
    applyStimulus(1'b1, 16'h000C, 32'h0, rd, er, w);
    checkOutput("commit_busy_err", {63'd0, er}, 64'd1);
    applyStimulus(1'b0, 16'h0018, 32'h0, rd, er, w);
    checkOutput("info_drop", {32'd0, rd}, 64'h0001_0001);
    checkOutput("cmd_addr_frozen", cmd_addr, 64'h2_0000_1000);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    checkOutput("cmd_accepted", {63'd0, cmd_valid}, 64'd0);
    applyStimulus(1'b0, 16'h0000, 32'h0, rd, er, w);
    checkOutput("addr_lo_updated", {32'd0, rd}, 64'hAAAA_0000);

    $display("[TB] read completion and beat stream");
    for (int i = 0; i < 4; i++) begin
      beatMem[i]   = 32'hB000_0001 + 32'(i);
      beatDelay[i] = (i == 1) ? 3 : 0;
      beatLast[i]  = (i == 3);
      expBeatQ.push_back(32'hB000_0001 + 32'(i));
      expWaitQ.push_back((i == 1) ? 3 : 0);
    end
    beatCount = 4;
    popBase = popCount; reqBase = reqCount;
    sts_valid = 1'b1; sts_tag = 4'd5; sts_num_beats = 8'd4; sts_is_write = 1'b0;
    expPopQ.push_back(4'd5);
    applyStimulus(1'b0, 16'h0010, 32'h0, rd, er, w);
    sts_valid = 1'b0;
    checkOutput("status_word", {32'd0, rd}, 64'h8004_0005);
    tick(3);
    checkOutput("pop_count", popCount - popBase, 1);
    checkOutput("pop_tag", {60'd0, lastPopTag}, {60'd0, expPopQ.pop_front()});
    checkOutput("req_count", reqCount - reqBase, 1);
    checkOutput("req_tag", {60'd0, lastReqTag}, 64'd5);
    applyStimulus(1'b0, 16'h0018, 32'h0, rd, er, w);
    checkOutput("info_streaming", {32'd0, rd}, 64'h0001_0004);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0014, 32'h0, rd, er, w);
      checkOutput("beat_err", {63'd0, er}, 64'd0);
      checkOutput("beat_data", {32'd0, rd}, {32'd0, expBeatQ.pop_front()});
      checkOutput("beat_waits", w, expWaitQ.pop_front());
    end
    applyStimulus(1'b0, 16'h0018, 32'h0, rd, er, w);
    checkOutput("info_idle_after_last", {32'd0, rd}, 64'h0001_0000);

    $display("[TB] write completion");
    popBase = popCount; reqBase = reqCount;
    sts_valid = 1'b1; sts_tag = 4'd7; sts_num_beats = 8'd1; sts_is_write = 1'b1;
    expPopQ.push_back(4'd7);
    applyStimulus(1'b0, 16'h0010, 32'h0, rd, er, w);
    sts_valid = 1'b0;
    checkOutput("status_write", {32'd0, rd}, 64'h8801_0007);
    tick(3);
    checkOutput("wr_pop_count", popCount - popBase, 1);
    checkOutput("wr_pop_tag", {60'd0, lastPopTag}, {60'd0, expPopQ.pop_front()});
    checkOutput("wr_no_req", reqCount - reqBase, 0);

    $display("[TB] stream timeout");
    popBase = popCount; reqBase = reqCount;
    sts_valid = 1'b1; sts_tag = 4'd3; sts_num_beats = 8'd2; sts_is_write = 1'b0;
    applyStimulus(1'b0, 16'h0010, 32'h0, rd, er, w);
    sts_valid = 1'b0;
    checkOutput("status_tmo", {32'd0, rd}, 64'h8002_0003);
    tick(3);
    checkOutput("tmo_req_tag", {60'd0, lastReqTag}, 64'd3);
    applyStimulus(1'b0, 16'h0014, 32'h0, rd, er, w);
    checkOutput("tmo_waits", w, 255);
    checkOutput("tmo_err", {63'd0, er}, 64'd1);
    checkOutput("tmo_data", {32'd0, rd}, 64'd0);
    applyStimulus(1'b0, 16'h0018, 32'h0, rd, er, w);
    checkOutput("info_tmo", {32'd0, rd}, 64'h0001_0104);
    applyStimulus(1'b0, 16'h0010, 32'h0, rd, er, w);
    checkOutput("status_busy", {32'd0, rd}, 64'h0402_0003);
    tick(2);
    checkOutput("busy_no_pop", popCount - popBase, 1);

`ifdef APB2AXI_REG_IRQ_EN
    $display("[TB] interrupt");
    applyStimulus(1'b1, 16'h001C, 32'h3, rd, er, w);
    checkOutput("irq_clear", {63'd0, irq}, 64'd0);
    sts_valid = 1'b1;
    tick(2);
    checkOutput("irq_set", {63'd0, irq}, 64'd1);
    applyStimulus(1'b1, 16'h001C, 32'h3, rd, er, w);
    checkOutput("irq_w1c", {63'd0, irq}, 64'd0);
    sts_valid = 1'b0;
    tick(1);
    sts_valid = 1'b1;
    tick(2);
    sts_valid = 1'b0;
    checkOutput("irq_reset_armed", {63'd0, irq}, 64'd1);
`endif

    $display("[TB] reset mid-stream and mid-commit");
    applyStimulus(1'b1, 16'h000C, 32'h0, rd, er, w);
    checkOutput("commit2_valid", {63'd0, cmd_valid}, 64'd1);
    popBase = popCount;
    presetn = 1'b0;
    tick(2);
    checkOutput("rst_mid_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    checkOutput("rst_mid_irq", {63'd0, irq}, 64'd0);
    presetn = 1'b1;
    tick(2);
    applyStimulus(1'b0, 16'h0018, 32'h0, rd, er, w);
    checkOutput("rst_mid_info", {32'd0, rd}, 64'd0);
    applyStimulus(1'b0, 16'h0014, 32'h0, rd, er, w);
    checkOutput("rst_mid_rd_data_err", {63'd0, er}, 64'd1);
    checkOutput("rst_mid_no_pop", popCount - popBase, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
